// File: rtl/commit_pkg.sv
// rtl/commit_pkg.sv - shared tag encodings and FSM states for the commit stage
package commit_pkg;

  localparam logic [1:0] TAG_REG = 2'b00;
  localparam logic [1:0] TAG_BR  = 2'b01;
  localparam logic [1:0] TAG_JAL = 2'b10;
  localparam logic [1:0] TAG_ST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_STORE_WAIT = 2'b01,
    ST_FLUSH      = 2'b10
  } state_e;

endpackage

// File: rtl/commit_perf_cnt.sv
// rtl/commit_perf_cnt.sv - free-running wrap-around performance counter with enable
module commit_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order retirement: pops the ROB head, then writes back,
// releases stores or flushes and redirects fetch on a mispredict
module commit_unit
  import commit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ID_W  = 5,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             commit_en_i,
  input  logic [ID_W-1:0]  commit_id_i,
  input  logic [REG_W-1:0] commit_regaddr_i,
  input  logic [XLEN-1:0]  commit_data_i,
  input  logic [XLEN-1:0]  commit_pc_i,
  input  logic [1:0]       commit_branch_tag_i,
  input  logic             commit_cond_i,
  output logic             commit_rdy_o,
  output logic             wb_en_o,
  output logic [REG_W-1:0] wb_addr_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic [ID_W-1:0]  wb_id_o,
  output logic             store_en_o,
  output logic [ID_W-1:0]  store_id_o,
  input  logic             store_done_i,
  output logic             rst_c_o,
  output logic             redirect_en_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  state_e           state_q;
  logic             wb_en_q, store_en_q, flush_q;
  logic [REG_W-1:0] wb_addr_q;
  logic [XLEN-1:0]  wb_data_q, redirect_pc_q;
  logic [ID_W-1:0]  wb_id_q, store_id_q;

  logic accept, is_write, is_ctrl, mispred;

  assign accept   = rdy & commit_en_i & (state_q == ST_IDLE);
  assign is_write = (commit_branch_tag_i == TAG_REG) | (commit_branch_tag_i == TAG_JAL);
  assign is_ctrl  = (commit_branch_tag_i == TAG_BR) | (commit_branch_tag_i == TAG_JAL);
  assign mispred  = accept & is_ctrl & commit_cond_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_id_q       <= '0;
      store_en_q    <= 1'b0;
      store_id_q    <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wb_en_q    <= 1'b0;
      store_en_q <= 1'b0;
      flush_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_write) begin
              wb_en_q   <= (commit_regaddr_i != '0);
              wb_addr_q <= commit_regaddr_i;
              wb_data_q <= commit_data_i;
              wb_id_q   <= commit_id_i;
            end
            if (mispred) begin
              flush_q       <= 1'b1;
              redirect_pc_q <= commit_pc_i;
              state_q       <= ST_FLUSH;
            end
            if (commit_branch_tag_i == TAG_ST) begin
              store_en_q <= 1'b1;
              store_id_q <= commit_id_i;
              state_q    <= ST_STORE_WAIT;
            end
          end
        end
        // Memory completion is not subject to the global stall.
        ST_STORE_WAIT: if (store_done_i) state_q <= ST_IDLE;
        ST_FLUSH:      if (rdy) state_q <= ST_IDLE;
        default:       state_q <= ST_IDLE;
      endcase
    end
  end

  assign commit_rdy_o  = accept;
  assign wb_en_o       = wb_en_q;
  assign wb_addr_o     = wb_addr_q;
  assign wb_data_o     = wb_data_q;
  assign wb_id_o       = wb_id_q;
  assign store_en_o    = store_en_q;
  assign store_id_o    = store_id_q;
  assign rst_c_o       = flush_q;
  assign redirect_en_o = flush_q;
  assign redirect_pc_o = redirect_pc_q;

  commit_perf_cnt #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en_i  (accept),
    .cnt_o (instret_o)
  );

  commit_perf_cnt #(.W(CNT_W)) u_mispred (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mispred),
    .cnt_o (mispred_cnt_o)
  );

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - directed vector table plus hand sequences for commit_unit
module tb_commit_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, commit_en_i, commit_cond_i, store_done_i;
  logic [4:0]  commit_id_i, commit_regaddr_i;
  logic [31:0] commit_data_i, commit_pc_i;
  logic [1:0]  commit_branch_tag_i;
  logic        commit_rdy_o, wb_en_o, store_en_o, rst_c_o, redirect_en_o;
  logic [4:0]  wb_addr_o, wb_id_o, store_id_o;
  logic [31:0] wb_data_o, redirect_pc_o, instret_o, mispred_cnt_o;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .commit_en_i         (commit_en_i),
    .commit_id_i         (commit_id_i),
    .commit_regaddr_i    (commit_regaddr_i),
    .commit_data_i       (commit_data_i),
    .commit_pc_i         (commit_pc_i),
    .commit_branch_tag_i (commit_branch_tag_i),
    .commit_cond_i       (commit_cond_i),
    .commit_rdy_o        (commit_rdy_o),
    .wb_en_o             (wb_en_o),
    .wb_addr_o           (wb_addr_o),
    .wb_data_o           (wb_data_o),
    .wb_id_o             (wb_id_o),
    .store_en_o          (store_en_o),
    .store_id_o          (store_id_o),
    .store_done_i        (store_done_i),
    .rst_c_o             (rst_c_o),
    .redirect_en_o       (redirect_en_o),
    .redirect_pc_o       (redirect_pc_o),
    .instret_o           (instret_o),
    .mispred_cnt_o       (mispred_cnt_o)
  );

  typedef struct {
    logic        rdy, en;
    logic [1:0]  tag;
    logic        cond;
    logic [4:0]  id, ra;
    logic [31:0] data, pc;
    logic        done;
    logic        x_rdy, x_wb;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
    logic [4:0]  x_wid;
    logic        x_st;
    logic [4:0]  x_sid;
    logic        x_fl;
    logic [31:0] x_pc, x_ir, x_mp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tv[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int r, int e, int tag, int cond, int id, int ra,
                              int unsigned data, int unsigned pc, int done,
                              int xr, int xwb, int xa, int unsigned xd, int xid,
                              int xst, int xsid, int xfl, int unsigned xpc,
                              int xir, int xmp);
    vec_t v;
    v.rdy = 1'(r);     v.en = 1'(e);       v.tag = 2'(tag);   v.cond = 1'(cond);
    v.id = 5'(id);     v.ra = 5'(ra);      v.data = data;     v.pc = pc;
    v.done = 1'(done); v.x_rdy = 1'(xr);   v.x_wb = 1'(xwb);  v.x_addr = 5'(xa);
    v.x_data = xd;     v.x_wid = 5'(xid);  v.x_st = 1'(xst);  v.x_sid = 5'(xsid);
    v.x_fl = 1'(xfl);  v.x_pc = xpc;       v.x_ir = 32'(xir); v.x_mp = 32'(xmp);
    return v;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [1:0] tag, input logic cond,
                       input logic [4:0] id, input logic [4:0] ra, input logic [31:0] data,
                       input logic [31:0] pc, input logic done);
    rdy = r; commit_en_i = e; commit_branch_tag_i = tag; commit_cond_i = cond;
    commit_id_i = id; commit_regaddr_i = ra; commit_data_i = data; commit_pc_i = pc;
    store_done_i = done;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wb_en"},    32'(wb_en_o), 32'd0);
    chk({tag, " wb_addr"},  32'(wb_addr_o), 32'd0);
    chk({tag, " wb_data"},  wb_data_o, 32'd0);
    chk({tag, " wb_id"},    32'(wb_id_o), 32'd0);
    chk({tag, " store_en"}, 32'(store_en_o), 32'd0);
    chk({tag, " store_id"}, 32'(store_id_o), 32'd0);
    chk({tag, " rst_c"},    32'(rst_c_o), 32'd0);
    chk({tag, " redir_en"}, 32'(redirect_en_o), 32'd0);
    chk({tag, " redir_pc"}, redirect_pc_o, 32'd0);
    chk({tag, " instret"},  instret_o, 32'd0);
    chk({tag, " mispred"},  mispred_cnt_o, 32'd0);
  endtask

  initial begin
    int n;
    logic stall;
    //            rdy en tag c id ra data      pc       dn | xr wb xa xdata     xid st sid fl xpc      ir mp
    tv[0]  = mk(1, 1, 0, 0, 3, 5, 32'hDEAD, 0,       0,   1, 1, 5, 32'hDEAD, 3,  0, 0,  0, 0,       1, 0);
    tv[1]  = mk(1, 1, 0, 0, 4, 0, 32'h1111, 0,       0,   1, 0, 0, 32'h1111, 4,  0, 0,  0, 0,       2, 0);
    tv[2]  = mk(1, 1, 1, 1, 5, 7, 32'h9999, 32'h1000,0,   1, 0, 0, 32'h1111, 4,  0, 0,  1, 32'h1000,3, 1);
    tv[3]  = mk(1, 1, 0, 0, 6, 9, 32'h2222, 0,       0,   0, 0, 0, 32'h1111, 4,  0, 0,  0, 32'h1000,3, 1);
    tv[4]  = mk(1, 1, 0, 0, 6, 9, 32'h2222, 0,       0,   1, 1, 9, 32'h2222, 6,  0, 0,  0, 32'h1000,4, 1);
    tv[5]  = mk(1, 1, 1, 0, 7, 3, 32'h3333, 32'h2000,0,   1, 0, 9, 32'h2222, 6,  0, 0,  0, 32'h1000,5, 1);
    tv[6]  = mk(1, 1, 2, 1, 8, 1, 32'h44,   32'h3000,0,   1, 1, 1, 32'h44,   8,  0, 0,  1, 32'h3000,6, 2);
    tv[7]  = mk(1, 1, 0, 0, 9, 2, 32'h55,   0,       0,   0, 0, 1, 32'h44,   8,  0, 0,  0, 32'h3000,6, 2);
    tv[8]  = mk(1, 1, 0, 1, 9, 2, 32'h55,   32'h7000,0,   1, 1, 2, 32'h55,   9,  0, 0,  0, 32'h3000,7, 2);
    tv[9]  = mk(1, 1, 3, 1, 7, 4, 32'hAB,   32'h7000,0,   1, 0, 2, 32'h55,   9,  1, 7,  0, 32'h3000,8, 2);
    tv[10] = mk(1, 1, 0, 0, 10,3, 32'h66,   0,       0,   0, 0, 2, 32'h55,   9,  0, 7,  0, 32'h3000,8, 2);
    tv[11] = mk(1, 1, 0, 0, 10,3, 32'h66,   0,       0,   0, 0, 2, 32'h55,   9,  0, 7,  0, 32'h3000,8, 2);
    tv[12] = mk(1, 1, 0, 0, 10,3, 32'h66,   0,       0,   0, 0, 2, 32'h55,   9,  0, 7,  0, 32'h3000,8, 2);
    tv[13] = mk(1, 1, 0, 0, 10,3, 32'h66,   0,       1,   0, 0, 2, 32'h55,   9,  0, 7,  0, 32'h3000,8, 2);
    tv[14] = mk(1, 1, 0, 0, 10,3, 32'h66,   0,       0,   1, 1, 3, 32'h66,   10, 0, 7,  0, 32'h3000,9, 2);
    tv[15] = mk(1, 1, 0, 0, 11,4, 32'h77,   0,       1,   1, 1, 4, 32'h77,   11, 0, 7,  0, 32'h3000,10,2);
    tv[16] = mk(0, 1, 0, 0, 12,5, 32'h88,   0,       0,   0, 0, 4, 32'h77,   11, 0, 7,  0, 32'h3000,10,2);
    tv[17] = mk(1, 1, 0, 0, 12,5, 32'h88,   0,       0,   1, 1, 5, 32'h88,   12, 0, 7,  0, 32'h3000,11,2);
    tv[18] = mk(0, 1, 3, 0, 13,0, 0,        0,       0,   0, 0, 5, 32'h88,   12, 0, 7,  0, 32'h3000,11,2);
    tv[19] = mk(1, 1, 3, 0, 13,0, 0,        0,       0,   1, 0, 5, 32'h88,   12, 1, 13, 0, 32'h3000,12,2);
    tv[20] = mk(0, 1, 0, 0, 14,6, 32'h99,   0,       1,   0, 0, 5, 32'h88,   12, 0, 13, 0, 32'h3000,12,2);
    tv[21] = mk(1, 1, 0, 0, 14,6, 32'h99,   0,       0,   1, 1, 6, 32'h99,   14, 0, 13, 0, 32'h3000,13,2);
    tv[22] = mk(1, 1, 1, 1, 15,0, 0,        32'h4000,0,   1, 0, 6, 32'h99,   14, 0, 13, 1, 32'h4000,14,3);
    tv[23] = mk(0, 1, 0, 0, 16,8, 32'hBB,   0,       0,   0, 0, 6, 32'h99,   14, 0, 13, 0, 32'h4000,14,3);
    tv[24] = mk(1, 1, 0, 0, 16,8, 32'hBB,   0,       0,   0, 0, 6, 32'h99,   14, 0, 13, 0, 32'h4000,14,3);
    tv[25] = mk(1, 0, 0, 0, 16,8, 32'hBB,   0,       0,   0, 0, 6, 32'h99,   14, 0, 13, 0, 32'h4000,14,3);

    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tv[i].rdy, tv[i].en, tv[i].tag, tv[i].cond, tv[i].id, tv[i].ra,
            tv[i].data, tv[i].pc, tv[i].done);
      #1;
      chk($sformatf("v%0d commit_rdy", i), 32'(commit_rdy_o), 32'(tv[i].x_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_en", i),    32'(wb_en_o),       32'(tv[i].x_wb));
      chk($sformatf("v%0d wb_addr", i),  32'(wb_addr_o),     32'(tv[i].x_addr));
      chk($sformatf("v%0d wb_data", i),  wb_data_o,          tv[i].x_data);
      chk($sformatf("v%0d wb_id", i),    32'(wb_id_o),       32'(tv[i].x_wid));
      chk($sformatf("v%0d store_en", i), 32'(store_en_o),    32'(tv[i].x_st));
      chk($sformatf("v%0d store_id", i), 32'(store_id_o),    32'(tv[i].x_sid));
      chk($sformatf("v%0d rst_c", i),    32'(rst_c_o),       32'(tv[i].x_fl));
      chk($sformatf("v%0d redir_en", i), 32'(redirect_en_o), 32'(tv[i].x_fl));
      chk($sformatf("v%0d redir_pc", i), redirect_pc_o,      tv[i].x_pc);
      chk($sformatf("v%0d instret", i),  instret_o,          tv[i].x_ir);
      chk($sformatf("v%0d mispred", i),  mispred_cnt_o,      tv[i].x_mp);
    end

    // eight back-to-back register writes with a one-cycle stall in the middle
    n = 0;
    for (int c = 0; c < 9; c++) begin
      stall = (c == 4);
      @(negedge clk);
      drive(!stall, 1'b1, 2'b00, 1'b0, 5'(16 + n), 5'(10 + n), 32'hA0 + 32'(n), 32'd0, 1'b0);
      #1;
      chk($sformatf("b2b%0d commit_rdy", c), 32'(commit_rdy_o), 32'(!stall));
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d wb_en", c), 32'(wb_en_o), 32'(!stall));
      if (!stall) begin
        chk($sformatf("b2b%0d wb_data", c), wb_data_o, 32'hA0 + 32'(n));
        chk($sformatf("b2b%0d wb_addr", c), 32'(wb_addr_o), 32'(10 + n));
        n++;
      end
    end
    chk("b2b instret", instret_o, 32'd22);

    // reset while waiting on a store
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b11, 1'b0, 5'd7, 5'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("rstsw store_en", 32'(store_en_o), 32'd1);
    @(negedge clk);
    commit_en_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rstsw");
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 5'd3, 5'd5, 32'h1234, 32'd0, 1'b0);
    #1;
    chk("rstsw idle commit_rdy", 32'(commit_rdy_o), 32'd1);
    @(posedge clk);
    #1;
    chk("rstsw wb_en", 32'(wb_en_o), 32'd1);
    chk("rstsw instret", instret_o, 32'd1);

    // reset during the flush cycle drops the pulse
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b01, 1'b1, 5'd4, 5'd0, 32'd0, 32'h5000, 1'b0);
    @(posedge clk);
    #1;
    chk("rstfl rst_c", 32'(rst_c_o), 32'd1);
    chk("rstfl mispred", mispred_cnt_o, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstfl rst_c cleared", 32'(rst_c_o), 32'd0);
    chk("rstfl redir cleared", 32'(redirect_en_o), 32'd0);
    chk("rstfl mispred cleared", mispred_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 5'd5, 5'd6, 32'h77, 32'd0, 1'b0);
    #1;
    chk("rstfl idle commit_rdy", 32'(commit_rdy_o), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
